// File: rtl/serial_subtractor8.sv
// serial_subtractor8: bit-serial subtractor computing a - b - borrow_in, LSB first,
// one bit per clock through a single full-subtractor cell.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, honoured only when busy = 0
//   a, b, borrow_in   operands, sampled in the accept cycle only
//   busy              operation in progress (WIDTH cycles)
//   done              one-cycle pulse; result outputs valid from this cycle on
//   diff              a - b - borrow_in modulo 2^WIDTH
//   borrow_out        final borrow (a < b + borrow_in, unsigned)
//   zero              diff == 0
//   overflow          two's-complement overflow of the subtraction
module serial_subtractor8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
    logic             br_q;
    logic             a_msb_q, b_msb_q;

    logic             accept;
    logic             last;
    logic             a_bit, b_bit, d_bit, br_next;
    logic [WIDTH-1:0] res_next;

    // New requests are taken in IDLE and also in DONE (back-to-back).
    assign accept = start & (state_q != StShift);
    assign last   = (state_q == StShift) & (cnt_q == LastBit);

    // Full-subtractor cell
    assign a_bit    = a_sr_q[0];
    assign b_bit    = b_sr_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == LastBit) state_d = StDone;
            StDone:  state_d = start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/result shift registers and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_sr_q  <= a;
            b_sr_q  <= b;
            res_q   <= '0;
            br_q    <= borrow_in;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == StShift) begin
            cnt_q  <= cnt_q + 1'b1;
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            res_q  <= res_next;
            br_q   <= br_next;
        end
    end

    // Result registers update only on the SHIFT->DONE edge and hold otherwise.
    // d_bit is the MSB of the final difference on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else if (last) begin
            diff       <= res_next;
            borrow_out <= br_next;
            zero       <= (res_next == '0);
            overflow   <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor8.sv
module tb_serial_subtractor8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out, zero, overflow;
    logic [W-1:0] diff;

    serial_subtractor8 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
        exp_t     e;
        logic [W:0] t;
        t        = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.diff   = t[W-1:0];
        e.borrow = t[W];
        e.zero   = (t[W-1:0] == '0);
        e.ovf    = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Call with clk low; returns 1 time unit after the accepting edge.
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        a         = x;
        b         = y;
        borrow_in = bi;
        start     = 1'b1;
        sb.push_back(model(x, y, bi));
        @(posedge clk);
        #1;
        start     = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
    endtask

    // elapsed: negedges already observed (all busy) since the accepting edge.
    task automatic wait_done(input string tag, input int elapsed);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat      = 0;
        busy_cnt = elapsed;
        for (int k = elapsed + 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_busy_with_done"}, 32'(busy), 32'(0));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_borrow_out"}, 32'(borrow_out), 32'(e.borrow));
            check({tag, "_zero"}, 32'(zero), 32'(e.zero));
            check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    initial begin
        int   done_seen;
        exp_t junk;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_flags", 32'({borrow_out, zero, overflow}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        drive_start(8'h50, 8'h20, 1'b0);
        wait_done("op_50_20", 0);
        drive_start(8'h20, 8'h50, 1'b0);
        wait_done("op_20_50", 0);
        drive_start(8'h80, 8'h01, 1'b0);
        wait_done("op_80_01", 0);
        drive_start(8'h00, 8'h00, 1'b1);
        wait_done("op_00_00_b1", 0);
        drive_start(8'h33, 8'h33, 1'b0);
        wait_done("op_33_33", 0);

        // Start while busy is ignored
        @(negedge clk);
        drive_start(8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_start", 3);

        // Back-to-back from the done cycle; previous result must hold meanwhile
        drive_start(8'h05, 8'h07, 1'b0);
        check("b2b_busy_next", 32'(busy), 32'(1));
        repeat (2) @(negedge clk);
        check("hold_diff", 32'(diff), 32'(8'h0F));
        wait_done("back_to_back", 2);

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive_start(8'h42, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_diff", 32'(diff), 32'(0));
        check("arst_flags", 32'({borrow_out, zero, overflow}), 32'(0));
        junk = sb.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("arst_no_done", 32'(done_seen), 32'(0));
        drive_start(8'h09, 8'h04, 1'b0);
        wait_done("after_reset", 0);

        // Randomized operations with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_start(W'($urandom), W'($urandom), 1'($urandom));
            wait_done("random", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Bit-serial, multi-cycle subtractor that computes a − b − borrow_in one bit per clock, LSB first, using a single full-subtractor cell and shift registers. It is the inverse-operation counterpart to the combinational ripple-carry adder chain in the 8-bit datapath, and serves the CPU's SUB/CMP path where area matters more than latency. A start/busy/done handshake connects it to the control unit. Results are held stable until the next operation completes.

## Interface
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  minuend; sampled in the cycle start is accepted.
- b  in  WIDTH  subtrahend; sampled with a.
- borrow_in  in  1  initial borrow; sampled with a.
- busy  out  1  high while the operation is in progress.
- done  out  1  single-cycle pulse; result outputs are valid from this cycle on.
- diff  out  WIDTH  a − b − borrow_in, modulo 2^WIDTH.
- borrow_out  out  1  final borrow; 1 when a < b + borrow_in (unsigned).
- zero  out  1  diff == 0.
- overflow  out  1  two's-complement overflow of the subtraction.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1, latch a, b and borrow_in into internal shift registers, clear bit counter, go to SHIFT.
- SHIFT: busy=1. Each cycle processes bit i = counter:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d_i into the MSB of the internal result register; shift the operand registers right; increment the counter.
- SHIFT exit: after the cycle that processes bit WIDTH−1, go to DONE. On that same edge, load the output registers:
  - diff ← internal result
  - borrow_out ← final br
  - zero ← (result == 0)
  - overflow ← (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the latched a and b.
- DONE: done=1, busy=0.
  - If start=1: accept a new operation exactly as in IDLE and go to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- start while busy=1 is ignored; no queuing.
- Output registers change only on the SHIFT→DONE edge. They hold their values through IDLE and through the following operation.
- Reset (any time, including mid-SHIFT): state=IDLE, counter=0, all internal registers 0, every output 0 (busy, done, diff, borrow_out, zero, overflow). The in-flight operation is discarded and no done is produced.

## Timing
- Start accepted at rising edge E0.
- busy is high in the cycles after edges E0 … E(WIDTH−1), which is WIDTH cycles.
- Edge E(WIDTH) enters DONE. done is high for exactly one cycle after E(WIDTH), with outputs updated on the same edge.
- Latency from start to done is WIDTH+1 edges (9 for WIDTH=8).
- Throughput is one operation per WIDTH+1 cycles, achieved when start is asserted during DONE.
- a, b and borrow_in need only be valid in the accept cycle. Changes afterward have no effect.
- done and busy are never high in the same cycle.

## Test plan
- Reset, then a=0x50, b=0x20, borrow_in=0, start for one cycle → busy high 8 cycles; done on the 9th edge; diff=0x30, borrow_out=0, zero=0, overflow=0.
- a=0x20, b=0x50 → diff=0xD0, borrow_out=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
- a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1, zero=0. Then a=0x33, b=0x33, borrow_in=0 → diff=0x00, zero=1, borrow_out=0.
- Start with a=0x10, b=0x01, then pulse start with a=0xFF, b=0xFF at busy cycle 3 → second request ignored; result diff=0x0F. Assert start during the done cycle with a=0x05, b=0x07 → busy the next cycle; done 9 edges later with diff=0xFE, borrow_out=1. Outputs hold 0x0F until then.
- Assert rst_n=0 asynchronously during busy cycle 4 → all outputs 0 immediately and no done. Release reset, then a=0x09, b=0x04 → diff=0x05 after 9 edges.
- Randomized: 1000 operations with random a, b, borrow_in and random start gaps, checked against a behavioural model for a − b − borrow_in (diff, borrow_out, zero, overflow) and for the done-latency rule.
